// File: rtl/snn_img_loader.sv
// Image front-end for the SNN core: unpacks UART bytes LSB-first into the 1-bit input RAM,
// starts the core, and returns the classified digit to the UART. Define SNN_LOADER_ASCII_EN for ASCII digit output.
module snn_img_loader #(
  parameter int NUM_BYTES = 98,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              ram_we,
  input  logic [ADDR_W-1:0] core_addr_in,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              overrun
);

  localparam int NUM_BITS = NUM_BYTES * 8;
  localparam int CNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    WAIT_BYTE,
    START,
    COMPUTE,
    SEND
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   byte_cnt;
  logic [2:0]         bit_cnt;
  logic [ADDR_W-1:0]  load_addr;
  logic [7:0]         shift;
  logic [3:0]         digit;
  logic               core_owns_ram;

  function automatic logic [7:0] encode_digit(input logic [3:0] d);
`ifdef SNN_LOADER_ASCII_EN
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
`else
    return {4'h0, d};
`endif
  endfunction

  // The core reads the input RAM from the moment it is started until the result has gone out.
  assign core_owns_ram = (state == START) || (state == COMPUTE) || (state == SEND);
  assign ram_addr      = core_owns_ram ? core_addr_in : load_addr;
  assign ram_we        = (state == UNPACK);
  assign ram_data      = (state == UNPACK) ? shift[0] : 1'b0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      load_addr  <= '0;
      shift      <= '0;
      digit      <= '0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      overrun    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      tx_start   <= 1'b0;

      // Bytes arriving while a byte is unpacking or the core owns the frame are lost.
      if (rx_rdy && (state inside {UNPACK, START, COMPUTE, SEND}))
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_rdy) begin
            shift     <= rx_data;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            load_addr <= '0;
            overrun   <= 1'b0;
            state     <= UNPACK;
          end
        end

        UNPACK: begin
          shift <= {1'b0, shift[7:1]};
          if (load_addr != LAST_ADDR)
            load_addr <= load_addr + ADDR_W'(1);
          if (bit_cnt == 3'd7) begin
            bit_cnt <= '0;
            if (byte_cnt == LAST_BYTE) begin
              core_start <= 1'b1;
              state      <= START;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
              state    <= WAIT_BYTE;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end

        WAIT_BYTE: begin
          if (rx_rdy) begin
            shift   <= rx_data;
            bit_cnt <= '0;
            state   <= UNPACK;
          end
        end

        START: begin
          state <= COMPUTE;
        end

        COMPUTE: begin
          if (core_done) begin
            digit <= core_digit;
            state <= SEND;
          end
        end

        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= encode_digit(digit);
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
